// File: rtl/reg_dest_scoreboard.sv
// Issue-stage destination scoreboard: per-register in-flight write counters,
// RAW / WAW-overflow stall generation, writeback retirement and squash.

module reg_dest_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             nz_nxt,
  output logic             pend
);
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (flush)            count_nxt = '0;
    else if (inc && !dec) count_nxt = count + CNT_W'(1);
    else if (dec && !inc) count_nxt = count - CNT_W'(1);
  end

  assign nz_nxt = (count_nxt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      pend  <= 1'b0;
    end else begin
      count <= count_nxt;
      pend  <= nz_nxt;
    end
  end
endmodule

module reg_dest_scoreboard #(
  parameter int NREG     = 8,
  parameter int PEND_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  input  logic [1:0]      reg_destsel,
  input  logic [2:0]      dest_out,
  input  logic [2:0]      src1,
  input  logic [2:0]      src2,
  input  logic            src1_en,
  input  logic            src2_en,
  input  logic            wb_valid,
  input  logic [2:0]      wb_reg,
  input  logic            flush,
  output logic            issue_ready,
  output logic            issue_fire,
  output logic [NREG-1:0] pending_mask,
  output logic            busy,
  output logic            wb_err
);
  localparam int CNT_W = 2;
  localparam int IDX_W = 3;

  logic [NREG-1:0][CNT_W-1:0] count;
  logic [NREG-1:0]            inc, dec, nz_nxt;
  logic                       has_dest, raw, waw_full, inc_to_wb;

  assign has_dest = (reg_destsel != 2'b11);

  // Hazards look only at registered counts; a same-cycle writeback never bypasses.
  assign raw = (src1_en && (count[src1] != '0)) || (src2_en && (count[src2] != '0));
  assign waw_full    = has_dest && (count[dest_out] == CNT_W'(PEND_MAX));
  assign issue_ready = !raw && !waw_full && !flush;
  assign issue_fire  = issue_valid && issue_ready;

  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign inc[r] = issue_fire && has_dest && (dest_out == IDX_W'(r));
    assign dec[r] = wb_valid && (wb_reg == IDX_W'(r)) && (count[r] != '0);

    reg_dest_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc[r]),
      .dec    (dec[r]),
      .flush  (flush),
      .count  (count[r]),
      .nz_nxt (nz_nxt[r]),
      .pend   (pending_mask[r])
    );
  end

  // A writeback to an idle register is legal only when it pairs with a same-cycle issue.
  assign inc_to_wb = issue_fire && has_dest && (dest_out == wb_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      wb_err <= 1'b0;
    end else begin
      busy <= |nz_nxt;
      if (wb_valid && (count[wb_reg] == '0) && !inc_to_wb) wb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_dest_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.

module tb_reg_dest_scoreboard;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [1:0] reg_destsel;
  logic [2:0] dest_out, src1, src2, wb_reg;
  logic       src1_en, src2_en, wb_valid, flush;
  logic       issue_ready, issue_fire, busy, wb_err;
  logic [7:0] pending_mask;

  typedef struct {
    string      name;
    logic       ready;
    logic       fire;
    logic [7:0] mask;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reg_dest_scoreboard #(.NREG(8), .PEND_MAX(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .reg_destsel  (reg_destsel),
    .dest_out     (dest_out),
    .src1         (src1),
    .src2         (src2),
    .src1_en      (src1_en),
    .src2_en      (src2_en),
    .wb_valid     (wb_valid),
    .wb_reg       (wb_reg),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .issue_fire   (issue_fire),
    .pending_mask (pending_mask),
    .busy         (busy),
    .wb_err       (wb_err)
  );

  // Monitor: every expectation queued during the cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk++;
      if ({issue_ready, issue_fire, pending_mask, busy, wb_err} !==
          {e.ready, e.fire, e.mask, e.busy, e.err}) begin
        n_fail++;
        $display("FAIL %s: got rdy=%b fire=%b mask=%h busy=%b err=%b, want rdy=%b fire=%b mask=%h busy=%b err=%b",
                 e.name, issue_ready, issue_fire, pending_mask, busy, wb_err,
                 e.ready, e.fire, e.mask, e.busy, e.err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; reg_destsel = 2'b11; dest_out = 3'd0;
    src1 = 3'd0; src2 = 3'd0; src1_en = 1'b0; src2_en = 1'b0;
    wb_valid = 1'b0; wb_reg = 3'd0; flush = 1'b0;
  endtask

  task automatic issue_dest(input logic [2:0] d);
    idle();
    issue_valid = 1'b1; reg_destsel = 2'b00; dest_out = d;
  endtask

  task automatic wb(input logic [2:0] r);
    wb_valid = 1'b1; wb_reg = r;
  endtask

  task automatic expect_out(input string n, input logic rdy, input logic [7:0] m, input logic e);
    exp_t x;
    x.name = n; x.ready = rdy; x.fire = issue_valid & rdy;
    x.mask = m; x.busy = (m != 8'h00); x.err = e;
    exp_q.push_back(x);
  endtask

  initial begin
    // 1. reset with arbitrary inputs
    idle();
    rst_n = 1'b0;
    issue_valid = 1'b1; reg_destsel = 2'b00; dest_out = 3'd5; wb(3'd2);
    step(); step();
    expect_out("reset_state", 1'b1, 8'h00, 1'b0);
    step();
    idle(); rst_n = 1'b1;
    issue_valid = 1'b1; src1 = 3'd2; src1_en = 1'b1;
    expect_out("post_reset_ready", 1'b1, 8'h00, 1'b0);

    // 2. RAW stall and release
    step(); issue_dest(3'd3);
    expect_out("issue_r3", 1'b1, 8'h00, 1'b0);
    step(); idle(); issue_valid = 1'b1; src1 = 3'd3; src1_en = 1'b1;
    expect_out("raw_stall", 1'b0, 8'h08, 1'b0);
    step(); wb(3'd3);
    expect_out("raw_no_bypass", 1'b0, 8'h08, 1'b0);
    step(); wb_valid = 1'b0;
    expect_out("raw_released", 1'b1, 8'h00, 1'b0);

    // 3. no-destination instruction
    step(); idle(); issue_valid = 1'b1; reg_destsel = 2'b11; dest_out = 3'd5;
    expect_out("nodest_issue", 1'b1, 8'h00, 1'b0);
    step(); idle();
    expect_out("nodest_mask", 1'b1, 8'h00, 1'b0);

    // 4. WAW saturation on R1
    step(); issue_dest(3'd1);
    expect_out("waw_1", 1'b1, 8'h00, 1'b0);
    step(); expect_out("waw_2", 1'b1, 8'h02, 1'b0);
    step(); expect_out("waw_3", 1'b1, 8'h02, 1'b0);
    step(); expect_out("waw_full", 1'b0, 8'h02, 1'b0);
    step(); wb(3'd1);
    expect_out("waw_full_wb_same", 1'b0, 8'h02, 1'b0);
    step(); wb_valid = 1'b0;
    expect_out("waw_after_wb", 1'b1, 8'h02, 1'b0);
    step(); idle(); wb(3'd1);
    expect_out("drain_1", 1'b1, 8'h02, 1'b0);
    step(); expect_out("drain_2", 1'b1, 8'h02, 1'b0);
    step(); expect_out("drain_3", 1'b1, 8'h02, 1'b0);
    step(); idle();
    expect_out("drained", 1'b1, 8'h00, 1'b0);

    // 5. simultaneous inc/dec, spurious writeback
    step(); issue_dest(3'd4);
    expect_out("r4_issue", 1'b1, 8'h00, 1'b0);
    step(); issue_dest(3'd4); wb(3'd4);
    expect_out("r4_inc_dec", 1'b1, 8'h10, 1'b0);
    step(); idle();
    expect_out("r4_held", 1'b1, 8'h10, 1'b0);
    step(); wb(3'd6);
    expect_out("spurious_wb", 1'b1, 8'h10, 1'b0);
    step(); idle();
    expect_out("wb_err_set", 1'b1, 8'h10, 1'b1);
    step(); wb(3'd4);
    expect_out("wb_err_sticky", 1'b1, 8'h10, 1'b1);
    step(); idle();
    expect_out("r4_retired", 1'b1, 8'h00, 1'b1);

    // 6. flush, then async reset mid-cycle
    step(); issue_dest(3'd0);
    expect_out("pend_r0", 1'b1, 8'h00, 1'b1);
    step(); issue_dest(3'd2);
    expect_out("pend_r2", 1'b1, 8'h01, 1'b1);
    step(); issue_dest(3'd7);
    expect_out("pend_r7", 1'b1, 8'h05, 1'b1);
    step(); idle(); flush = 1'b1; issue_valid = 1'b1;
    expect_out("flush_blocks", 1'b0, 8'h85, 1'b1);
    step(); idle();
    expect_out("flush_cleared", 1'b1, 8'h00, 1'b1);
    step(); issue_dest(3'd2);
    expect_out("repend_r2", 1'b1, 8'h00, 1'b1);
    step(); idle();
    expect_out("r2_pending", 1'b1, 8'h04, 1'b1);
    step(); rst_n = 1'b0;
    expect_out("async_reset", 1'b1, 8'h00, 1'b0);
    step(); rst_n = 1'b1;
    expect_out("after_reset", 1'b1, 8'h00, 1'b0);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
